// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx_arbiter slice.
//   arb_state_e : arbiter FSM states (IDLE=0, LOAD=1, SEND=2)
//   UART_DW     : byte width of the attached uart
//   rot_idx     : index 'off' steps after 'base', modulo n
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } arb_state_e;

  localparam int unsigned UART_DW = 8;

  function automatic int unsigned rot_idx(int unsigned base, int unsigned off, int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority encoder.
//   req : request vector, one bit per requester
//   ptr : index holding highest priority this round
//   any : at least one request is set
//   idx : first set request scanning ptr, ptr+1, ... mod NREQ
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      logic [IW-1:0] cand;
      cand = IW'(rot_idx(32'(ptr), k, NREQ));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter between NREQ byte producers with round-robin
// priority; a grant is held for a packet (until req_last, a valid drop, or
// MAX_BURST bytes).
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester byte available
//   req_data     : packed bytes, requester i at [i*DW +: DW]
//   req_last     : per-requester last-byte-of-packet flag
//   req_ready    : one-hot pulse, byte of the holder captured this cycle
//   uart_wr_en   : write strobe to uart, held until uart drops wr_rdy
//   uart_din     : registered byte to uart
//   uart_wr_rdy  : uart idle
//   grant_valid  : a requester holds the grant
//   grant_id     : index of the holder
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = UART_DW,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     uart_wr_en,
  output logic [DW-1:0]            uart_din,
  input  logic                     uart_wr_rdy,
  output logic                     grant_valid,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e     state_q;
  logic [IW-1:0]  grant_id_q;
  logic           grant_valid_q;
  logic [IW-1:0]  rr_ptr_q;
  logic [IW-1:0]  rr_ptr_d;
  logic [CW-1:0]  burst_cnt_q;
  logic           last_q;
  logic [DW-1:0]  din_q;
  logic           wr_en_q;

  logic [DW-1:0]  data_arr [NREQ];
  logic           pick_any;
  logic [IW-1:0]  pick_idx;
  logic           cur_valid;
  logic           capture;
  logic           burst_done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    for (int unsigned k = 0; k < NREQ; k++) begin
      data_arr[k] = req_data[k*DW +: DW];
    end
  end

  assign cur_valid  = req_valid[grant_id_q];
  // Reset wins over a capture so a requester never pops a byte the arbiter dropped.
  assign capture    = (state_q == LOAD) && cur_valid && uart_wr_rdy && !rst;
  assign req_ready  = capture ? (NREQ'(1) << grant_id_q) : '0;
  assign burst_done = (burst_cnt_q == CW'(MAX_BURST));

  // Pointer after release: the departing holder drops to lowest priority.
  always_comb begin
    rr_ptr_d = grant_id_q + 1'b1;
    if (32'(grant_id_q) == NREQ - 1) rr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
      burst_cnt_q   <= '0;
      last_q        <= 1'b0;
      din_q         <= '0;
      wr_en_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_id_q    <= pick_idx;
            grant_valid_q <= 1'b1;
            burst_cnt_q   <= '0;
            state_q       <= LOAD;
          end
        end
        LOAD: begin
          if (!cur_valid) begin
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= IDLE;
          end else if (uart_wr_rdy) begin
            din_q       <= data_arr[grant_id_q];
            last_q      <= req_last[grant_id_q];
            burst_cnt_q <= burst_cnt_q + 1'b1;
            wr_en_q     <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // wr_rdy low means the uart has latched din and started its frame.
          if (!uart_wr_rdy) begin
            wr_en_q <= 1'b0;
            if (last_q || burst_done) begin
              grant_valid_q <= 1'b0;
              rr_ptr_q      <= rr_ptr_d;
              state_q       <= IDLE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_wr_en  = wr_en_q;
  assign uart_din    = din_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          uart_wr_en;
  logic [7:0]    uart_din;
  logic          uart_wr_rdy;
  logic          grant_valid;
  logic [1:0]    grant_id;

  uart_tx_arbiter #(
    .NREQ      (NR),
    .DW        (8),
    .MAX_BURST (MAXB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_wr_en  (uart_wr_en),
    .uart_din    (uart_din),
    .uart_wr_rdy (uart_wr_rdy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // producers
  logic [7:0] qd [NR][$];
  bit         ql [NR][$];
  bit         hold [NR];
  int         ready_cnt [NR];

  // uart line model
  bit u_rdy = 1'b1;
  int busy  = 0;
  int fr_lo = 4;
  int fr_hi = 4;
  logic [7:0] rx [$];

  // behavioural arbiter model: who holds the grant, whether a byte is in flight
  bit         m_gv   = 0;
  int         m_gid  = 0;
  int         m_ptr  = 0;
  int         m_cnt  = 0;
  bit         m_pend = 0;
  bit         m_last = 0;
  logic [7:0] m_din  = 8'h00;
  logic [7:0] exp_q [$];
  int         gq [$];
  bit         prev_gv = 0;

  // last observed DUT outputs
  bit         obs_gv, obs_wr;
  logic [7:0] obs_din;
  logic [3:0] obs_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return 0;
  endfunction

  task automatic apply_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = (qd[i].size() > 0) && !hold[i];
      req_data[i*8 +: 8]   = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
      req_last[i]          = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
    end
    uart_wr_rdy = u_rdy;
  endtask

  task automatic release_grant();
    m_gv  = 0;
    m_ptr = (m_gid + 1) % NR;
  endtask

  task automatic cycle();
    logic [3:0] want_ready;
    apply_inputs();
    @(negedge clk);
    obs_gv = grant_valid; obs_wr = uart_wr_en; obs_din = uart_din; obs_ready = req_ready;

    want_ready = (!rst && m_gv && !m_pend && req_valid[m_gid] && uart_wr_rdy) ? 4'(1 << m_gid) : 4'h0;
    check("grant_valid", grant_valid, m_gv);
    if (m_gv) check("grant_id", grant_id, m_gid);
    check("uart_wr_en", uart_wr_en, m_pend);
    check("uart_din", uart_din, m_din);
    check("req_ready", req_ready, want_ready);

    if (grant_valid && !prev_gv) gq.push_back(int'(grant_id));
    prev_gv = grant_valid;

    // model next state from this cycle's inputs
    if (rst) begin
      m_gv = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_pend = 0; m_last = 0; m_din = 8'h00;
    end else if (!m_gv) begin
      if (req_valid != 0) begin
        m_gid = pick(req_valid, m_ptr);
        m_gv  = 1;
        m_cnt = 0;
      end
    end else if (!m_pend) begin
      if (!req_valid[m_gid]) release_grant();
      else if (uart_wr_rdy) begin
        m_pend = 1;
        m_din  = req_data[m_gid*8 +: 8];
        m_last = req_last[m_gid];
        m_cnt++;
        exp_q.push_back(m_din);
      end
    end else if (!uart_wr_rdy) begin
      m_pend = 0;
      if (m_last || m_cnt == MAXB) release_grant();
    end

    // uart: latches din when idle and strobed, then busy for a frame
    if (uart_wr_rdy && uart_wr_en) begin
      rx.push_back(uart_din);
      check("uart_byte_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("uart_byte", uart_din, exp_q.pop_front());
      busy  = $urandom_range(fr_hi, fr_lo);
      u_rdy = 0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) u_rdy = 1;
    end

    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && qd[i].size() > 0) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
        ready_cnt[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit quiet();
    bit q;
    q = !obs_gv && !obs_wr && u_rdy && (busy == 0) && (exp_q.size() == 0);
    for (int i = 0; i < NR; i++) if (qd[i].size() != 0) q = 0;
    return q;
  endfunction

  task automatic run_until_idle(input string name, input int maxc);
    int n;
    n = 0;
    cycle();
    while (!quiet() && n < maxc) begin
      cycle();
      n++;
    end
    if (n >= maxc) check({name, "_timeout"}, n, 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit last);
    qd[i].push_back(d);
    ql[i].push_back(last);
  endtask

  task automatic start_scn();
    rx.delete();
    gq.delete();
    for (int i = 0; i < NR; i++) ready_cnt[i] = 0;
  endtask

  task automatic check_rx(input string name, input logic [7:0] w [$]);
    check({name, "_rx_count"}, rx.size(), w.size());
    for (int k = 0; k < w.size() && k < rx.size(); k++) check({name, "_rx_byte"}, rx[k], w[k]);
  endtask

  task automatic check_gq(input string name, input int w [$]);
    check({name, "_grant_count"}, gq.size(), w.size());
    for (int k = 0; k < w.size() && k < gq.size(); k++) check({name, "_grant_order"}, gq[k], w[k]);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < NR; i++) hold[i] = 0;
    req_valid = '0; req_data = '0; req_last = '0; uart_wr_rdy = 1'b1;

    reset_dut();
    check("reset_grant_valid", obs_gv, 0);
    check("reset_wr_en", obs_wr, 0);
    check("reset_din", obs_din, 0);
    check("reset_ready", obs_ready, 0);

    // 1: single byte from req0, then pointer has moved past 0
    start_scn();
    push(0, 8'hE8, 1);
    run_until_idle("t1", 200);
    check_rx("t1", '{8'hE8});
    check("t1_ready_pulses", ready_cnt[0], 1);
    start_scn();
    push(0, 8'h10, 1);
    push(1, 8'h20, 1);
    run_until_idle("t1b", 200);
    check_gq("t1b", '{1, 0});
    check_rx("t1b", '{8'h20, 8'h10});

    // 2: all four at once from pointer 0
    reset_dut();
    start_scn();
    for (int i = 0; i < NR; i++) push(i, 8'hA0 + 8'(i), 1);
    run_until_idle("t2", 300);
    check_gq("t2", '{0, 1, 2, 3});
    check_rx("t2", '{8'hA0, 8'hA1, 8'hA2, 8'hA3});

    // 3: packet hold
    start_scn();
    push(1, 8'h11, 0); push(1, 8'h22, 0); push(1, 8'h33, 1);
    push(2, 8'h44, 1);
    run_until_idle("t3", 300);
    check_gq("t3", '{1, 2});
    check_rx("t3", '{8'h11, 8'h22, 8'h33, 8'h44});

    // 4: burst limit
    reset_dut();
    start_scn();
    for (int k = 1; k <= 6; k++) push(0, 8'(k), 0);
    push(3, 8'h5A, 1);
    run_until_idle("t4", 400);
    check_gq("t4", '{0, 3, 0});
    check_rx("t4", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h5A, 8'h05, 8'h06});

    // 5: abandon in LOAD
    start_scn();
    push(2, 8'h77, 1);
    cycle();
    hold[2] = 1;
    cycle();
    check("t5_load_grant", obs_gv, 1);
    check("t5_load_ready", obs_ready, 0);
    cycle();
    check("t5_idle_grant", obs_gv, 0);
    check("t5_idle_wr_en", obs_wr, 0);
    hold[2] = 0;
    push(3, 8'hC3, 1);
    push(0, 8'hC0, 1);
    run_until_idle("t5", 300);
    check_gq("t5", '{2, 3, 0, 2});
    check_rx("t5", '{8'hC3, 8'hC0, 8'h77});

    // 6: reset during SEND, next request waits for uart idle
    reset_dut();
    start_scn();
    fr_lo = 6; fr_hi = 6;
    push(1, 8'h5C, 1);
    n = 0;
    cycle();
    while (!obs_wr && n < 50) begin cycle(); n++; end
    check("t6_send_reached", obs_wr, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    push(2, 8'h99, 1);
    cycle();
    check("t6_post_rst_grant", obs_gv, 0);
    check("t6_post_rst_wr_en", obs_wr, 0);
    check("t6_post_rst_din", obs_din, 0);
    check("t6_post_rst_ready", obs_ready, 0);
    run_until_idle("t6", 300);
    check_rx("t6", '{8'h5C, 8'h99});

    // random traffic against the model
    fr_lo = 1; fr_hi = 6;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 7) == 0 && qd[i].size() < 6)
          push(i, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
        if ($urandom_range(0, 15) == 0) hold[i] = !hold[i];
      end
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b0;
    for (int i = 0; i < NR; i++) hold[i] = 0;
    run_until_idle("rand_drain", 3000);
    check("rand_no_lost_bytes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
